// File: rtl/model_io_shell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : model_io_shell
//  Description : Host-side I/O shell around a streaming inference model.
//                The host loads an input vector word by word and commits it.
//                The shell streams the vector to the model over valid/ready,
//                collects the model's output stream into a result buffer and
//                flags completion. The host then reads the result back word
//                by word, with the read pointer wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module model_io_shell #(
    parameter int W         = 8,
    parameter int IN_WORDS  = 8,
    parameter int OUT_WORDS = 8
) (
    input  logic         clk_100mhz,
    input  logic         sys_rst,
    // host side
    input  logic         wr_in,
    input  logic [W-1:0] in_data,
    input  logic         in_data_ready,
    input  logic         rd_out,
    output logic [W-1:0] out_data,
    output logic         ml_inf_valid,
    output logic         busy,
    output logic [2:0]   err,
    // model input stream
    output logic [W-1:0] m_in_data,
    output logic         m_in_valid,
    output logic         m_in_last,
    input  logic         m_in_ready,
    // model output stream
    input  logic [W-1:0] m_out_data,
    input  logic         m_out_valid,
    input  logic         m_out_last,
    output logic         m_out_ready
);

    // Pointers can hold the full count N; array indices only need log2(N).
    localparam int c_ipw = $clog2(IN_WORDS + 1);
    localparam int c_opw = $clog2(OUT_WORDS + 1);
    localparam int c_iaw = (IN_WORDS  > 1) ? $clog2(IN_WORDS)  : 1;
    localparam int c_oaw = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

    localparam logic [c_ipw-1:0] c_in_full  = c_ipw'(IN_WORDS);
    localparam logic [c_ipw-1:0] c_in_last  = c_ipw'(IN_WORDS - 1);
    localparam logic [c_ipw-1:0] c_in_one   = c_ipw'(1);
    localparam logic [c_opw-1:0] c_out_last = c_opw'(OUT_WORDS - 1);
    localparam logic [c_opw-1:0] c_out_one  = c_opw'(1);

    localparam logic [1:0] c_st_load    = 2'd0;
    localparam logic [1:0] c_st_feed    = 2'd1;
    localparam logic [1:0] c_st_collect = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_ipw-1:0] r_wr_ptr;
    logic [c_ipw-1:0] w_wr_ptr_nxt;
    logic [c_ipw-1:0] w_wr_after;
    logic [c_ipw-1:0] r_feed_ptr;
    logic [c_ipw-1:0] w_feed_ptr_nxt;
    logic [c_opw-1:0] r_col_ptr;
    logic [c_opw-1:0] w_col_ptr_nxt;
    logic [c_opw-1:0] r_rd_ptr;
    logic [c_opw-1:0] w_rd_ptr_nxt;
    logic             r_ml_inf_valid;
    logic             w_ml_inf_valid_nxt;
    logic [2:0]       r_err;
    logic [2:0]       w_err_nxt;

    logic [W-1:0]     r_in_buf  [0:IN_WORDS-1];
    logic [W-1:0]     r_out_buf [0:OUT_WORDS-1];

    logic             w_in_we;
    logic [c_iaw-1:0] w_in_widx;
    logic             w_out_we;

    logic [c_iaw-1:0] w_feed_idx;
    logic [c_oaw-1:0] w_col_idx;
    logic [c_oaw-1:0] w_rd_idx;

    assign w_feed_idx = r_feed_ptr[c_iaw-1:0];
    assign w_col_idx  = r_col_ptr[c_oaw-1:0];
    assign w_rd_idx   = r_rd_ptr[c_oaw-1:0];

    // Next-state, pointer, flag and buffer-write-enable logic.
    always_comb begin
        w_state_nxt        = r_state;
        w_wr_ptr_nxt       = r_wr_ptr;
        w_wr_after         = r_wr_ptr;
        w_feed_ptr_nxt     = r_feed_ptr;
        w_col_ptr_nxt      = r_col_ptr;
        w_rd_ptr_nxt       = r_rd_ptr;
        w_ml_inf_valid_nxt = r_ml_inf_valid;
        w_err_nxt          = r_err;
        w_in_we            = 1'b0;
        w_in_widx          = r_wr_ptr[c_iaw-1:0];
        w_out_we           = 1'b0;

        case (r_state)
            c_st_load: begin
                // A same-cycle write lands first; commit sees the bumped pointer.
                if (wr_in) begin
                    if (r_wr_ptr < c_in_full) begin
                        w_in_we    = 1'b1;
                        w_wr_after = r_wr_ptr + c_in_one;
                    end else begin
                        w_err_nxt[0] = 1'b1;
                    end
                end
                w_wr_ptr_nxt = w_wr_after;
                if (in_data_ready) begin
                    if (w_wr_after == c_in_full) begin
                        w_state_nxt    = c_st_feed;
                        w_wr_ptr_nxt   = '0;
                        w_feed_ptr_nxt = '0;
                    end else begin
                        w_err_nxt[1] = 1'b1;
                    end
                end
            end

            c_st_feed: begin
                if (m_in_ready) begin
                    if (r_feed_ptr == c_in_last) begin
                        w_state_nxt    = c_st_collect;
                        w_feed_ptr_nxt = '0;
                        w_col_ptr_nxt  = '0;
                    end else begin
                        w_feed_ptr_nxt = r_feed_ptr + c_in_one;
                    end
                end
            end

            c_st_collect: begin
                if (m_out_valid) begin
                    w_out_we = 1'b1;
                    // Completion goes by word count; last is only cross-checked.
                    if (r_col_ptr == c_out_last) begin
                        w_state_nxt        = c_st_done;
                        w_ml_inf_valid_nxt = 1'b1;
                        w_rd_ptr_nxt       = '0;
                        w_col_ptr_nxt      = '0;
                        if (!m_out_last) begin
                            w_err_nxt[2] = 1'b1;
                        end
                    end else begin
                        w_col_ptr_nxt = r_col_ptr + c_out_one;
                        if (m_out_last) begin
                            w_err_nxt[2] = 1'b1;
                        end
                    end
                end
            end

            default: begin
                if (rd_out) begin
                    w_rd_ptr_nxt = (r_rd_ptr == c_out_last) ? '0 : r_rd_ptr + c_out_one;
                end
                if (wr_in) begin
                    // A new write starts a fresh load at word 0.
                    w_state_nxt        = c_st_load;
                    w_ml_inf_valid_nxt = 1'b0;
                    w_in_we            = 1'b1;
                    w_in_widx          = '0;
                    w_wr_ptr_nxt       = c_in_one;
                    if (in_data_ready) begin
                        if (c_in_one == c_in_full) begin
                            w_state_nxt    = c_st_feed;
                            w_wr_ptr_nxt   = '0;
                            w_feed_ptr_nxt = '0;
                        end else begin
                            w_err_nxt[1] = 1'b1;
                        end
                    end
                end else if (in_data_ready) begin
                    // Input buffer is still intact: re-run the same vector.
                    w_state_nxt        = c_st_feed;
                    w_ml_inf_valid_nxt = 1'b0;
                    w_feed_ptr_nxt     = '0;
                end
            end
        endcase
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk_100mhz or posedge sys_rst) begin
        if (sys_rst) begin
            r_state        <= c_st_load;
            r_wr_ptr       <= '0;
            r_feed_ptr     <= '0;
            r_col_ptr      <= '0;
            r_rd_ptr       <= '0;
            r_ml_inf_valid <= 1'b0;
            r_err          <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_feed_ptr     <= w_feed_ptr_nxt;
            r_col_ptr      <= w_col_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_ml_inf_valid <= w_ml_inf_valid_nxt;
            r_err          <= w_err_nxt;
        end
    end

    // Input vector buffer, written by the host.
    always_ff @(posedge clk_100mhz or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < IN_WORDS; i++) begin
                r_in_buf[i] <= '0;
            end
        end else if (w_in_we) begin
            r_in_buf[w_in_widx] <= in_data;
        end
    end

    // Result buffer, written by accepted model output beats.
    always_ff @(posedge clk_100mhz or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < OUT_WORDS; i++) begin
                r_out_buf[i] <= '0;
            end
        end else if (w_out_we) begin
            r_out_buf[w_col_idx] <= m_out_data;
        end
    end

    assign m_in_valid   = (r_state == c_st_feed);
    assign m_in_data    = r_in_buf[w_feed_idx];
    assign m_in_last    = m_in_valid && (r_feed_ptr == c_in_last);
    assign m_out_ready  = (r_state == c_st_collect);
    assign busy         = m_in_valid | m_out_ready;
    assign out_data     = r_out_buf[w_rd_idx];
    assign ml_inf_valid = r_ml_inf_valid;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_model_io_shell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_model_io_shell
//  Description : Directed self-checking bench for model_io_shell with a
//                behavioural streaming model (loopback +1, reversed
//                bias/ReLU, and an early-last variant).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_model_io_shell;

    logic       clk_100mhz = 1'b0;
    logic       sys_rst;
    logic       wr_in;
    logic [7:0] in_data;
    logic       in_data_ready;
    logic       rd_out;
    logic [7:0] out_data;
    logic       ml_inf_valid;
    logic       busy;
    logic [2:0] err;
    logic [7:0] m_in_data;
    logic       m_in_valid;
    logic       m_in_last;
    logic       m_in_ready;
    logic [7:0] m_out_data;
    logic       m_out_valid;
    logic       m_out_last;
    logic       m_out_ready;

    always #5 clk_100mhz = ~clk_100mhz;

    model_io_shell #(.W(8), .IN_WORDS(8), .OUT_WORDS(8)) dut (
        .clk_100mhz   (clk_100mhz),
        .sys_rst      (sys_rst),
        .wr_in        (wr_in),
        .in_data      (in_data),
        .in_data_ready(in_data_ready),
        .rd_out       (rd_out),
        .out_data     (out_data),
        .ml_inf_valid (ml_inf_valid),
        .busy         (busy),
        .err          (err),
        .m_in_data    (m_in_data),
        .m_in_valid   (m_in_valid),
        .m_in_last    (m_in_last),
        .m_in_ready   (m_in_ready),
        .m_out_data   (m_out_data),
        .m_out_valid  (m_out_valid),
        .m_out_last   (m_out_last),
        .m_out_ready  (m_out_ready)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [7:0]  d;
        logic        l;
        logic [31:0] due;
    } beat_t;

    beat_t       q[$];
    beat_t       b;
    int          mode = 0;          // 0 loopback, 1 reverse+bias+ReLU, 2 loopback with last on beat 6
    bit          ready_toggle = 0;
    logic [31:0] cyc = 0;
    int          ph = 0;
    int          in_cnt = 0;
    logic [7:0]  xbuf [0:7];
    logic [7:0]  rx [0:15];
    int          rx_cnt = 0;
    int          last_cnt = 0;
    int          out_beats = 0;
    int          in_valid_cycles = 0;
    int          stall_viol = 0;
    bit          stall_prev = 0;
    logic [7:0]  stall_data = '0;
    bit          in_pend = 0;
    bit          out_pend = 0;
    logic [7:0]  pend_d = '0;
    logic        pend_l = 1'b0;
    int          v;

    // Model runs on the falling edge: retire the handshakes of the last
    // rising edge, then present new stream signals for the next one.
    always @(negedge clk_100mhz) begin
        cyc = cyc + 1;
        if (sys_rst) begin
            q.delete();
            in_pend = 0; out_pend = 0; stall_prev = 0;
            in_cnt = 0; ph = 0;
            m_in_ready = 1'b0; m_out_valid = 1'b0;
            m_out_data = '0; m_out_last = 1'b0;
        end else begin
            if (in_pend) begin
                rx[rx_cnt % 16] = pend_d;
                rx_cnt++;
                if (pend_l) last_cnt++;
                xbuf[in_cnt] = pend_d;
                if (mode == 1) begin
                    if (in_cnt == 7) begin
                        for (int j = 0; j < 8; j++) begin
                            v = $signed(xbuf[7-j]) + j + 1;
                            b.d = (v < 0) ? 8'd0 : 8'(v);
                            b.l = (j == 7);
                            b.due = cyc + 2;
                            q.push_back(b);
                        end
                    end
                end else begin
                    b.d = pend_d + 8'd1;
                    b.l = (mode == 2) ? (in_cnt == 5) : pend_l;
                    b.due = cyc + 1;
                    q.push_back(b);
                end
                in_cnt = (in_cnt == 7) ? 0 : in_cnt + 1;
            end
            if (out_pend) begin
                void'(q.pop_front());
                out_beats++;
            end
            if (stall_prev && m_in_valid && (m_in_data !== stall_data)) stall_viol++;
            if (m_in_valid) in_valid_cycles++;
            m_in_ready = ready_toggle ? ((ph == 0) || (ph == 3)) : 1'b1;
            ph = (ph + 1) % 4;
            stall_prev = m_in_valid && !m_in_ready;
            stall_data = m_in_data;
            if ((q.size() > 0) && (q[0].due <= cyc)) begin
                m_out_valid = 1'b1; m_out_data = q[0].d; m_out_last = q[0].l;
            end else begin
                m_out_valid = 1'b0; m_out_data = '0; m_out_last = 1'b0;
            end
            in_pend  = m_in_valid && m_in_ready;
            pend_d   = m_in_data;
            pend_l   = m_in_last;
            out_pend = m_out_valid && m_out_ready;
        end
    end

    // ---------------- host drivers ----------------
    task automatic tick();
        @(negedge clk_100mhz);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        wr_in = 1'b1; in_data = d;
        tick();
        wr_in = 1'b0;
    endtask

    task automatic commit();
        in_data_ready = 1'b1;
        tick();
        in_data_ready = 1'b0;
    endtask

    task automatic read_step();
        rd_out = 1'b1;
        tick();
        rd_out = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            if (ml_inf_valid === 1'b1) begin ok = 1; break; end
            tick();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        sys_rst = 1'b1; wr_in = 1'b0; in_data = '0; in_data_ready = 1'b0; rd_out = 1'b0;
        tick(); tick(); tick();
        sys_rst = 1'b0;
        tick();
        checks++; if (ml_inf_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", ml_inf_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL rst_err: got %b expected 000", err); end
        checks++; if (m_in_valid !== 1'b0 || m_in_last !== 1'b0) begin errors++; $display("FAIL rst_m_in: valid=%b last=%b expected 0 0", m_in_valid, m_in_last); end
        checks++; if (m_out_ready !== 1'b0) begin errors++; $display("FAIL rst_m_out_ready: got %b expected 0", m_out_ready); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h expected 00", out_data); end
    endtask

    task automatic test_loopback();
        bit ok;
        mode = 0; ready_toggle = 0;
        for (int i = 0; i < 8; i++) write_word(8'(i));
        in_valid_cycles = 0;
        commit();
        checks++; if (m_in_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL loop_feed_start: m_in_valid=%b busy=%b expected 1 1", m_in_valid, busy); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL loop_done_timeout: ml_inf_valid=%b expected 1", ml_inf_valid); end
        checks++; if (in_valid_cycles != 8) begin errors++; $display("FAIL loop_feed_cycles: got %0d expected 8", in_valid_cycles); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL loop_err: got %b expected 000", err); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_data !== 8'(i + 1)) begin errors++; $display("FAIL loop_read[%0d]: got %h expected %h", i, out_data, 8'(i + 1)); end
            read_step();
        end
    endtask

    task automatic test_relu();
        bit ok;
        logic [7:0] exp_v [0:7];
        exp_v = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd3, 8'd5, 8'd7};
        mode = 1;
        for (int i = 0; i < 8; i++) write_word(8'(-(i + 1)));
        commit();
        wait_done(300, ok);
        checks++; if (!ok) begin errors++; $display("FAIL relu_done_timeout: ml_inf_valid=%b expected 1", ml_inf_valid); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_data !== exp_v[i]) begin errors++; $display("FAIL relu_read[%0d]: got %h expected %h", i, out_data, exp_v[i]); end
            read_step();
        end
        checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL relu_wrap0: got %h expected 00", out_data); end
        for (int i = 0; i < 4; i++) read_step();
        checks++; if (out_data !== 8'd1) begin errors++; $display("FAIL relu_wrap4: got %h expected 01", out_data); end
    endtask

    task automatic test_stall();
        bit ok;
        mode = 0; ready_toggle = 1;
        last_cnt = 0; rx_cnt = 0; stall_viol = 0;
        for (int i = 0; i < 8; i++) write_word(8'(10 + i));
        commit();
        wait_done(300, ok);
        ready_toggle = 0;
        checks++; if (!ok) begin errors++; $display("FAIL stall_done_timeout: ml_inf_valid=%b expected 1", ml_inf_valid); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL stall_stable: got %0d changes expected 0", stall_viol); end
        checks++; if (last_cnt != 1) begin errors++; $display("FAIL stall_last_count: got %0d expected 1", last_cnt); end
        checks++; if (rx_cnt != 8) begin errors++; $display("FAIL stall_word_count: got %0d expected 8", rx_cnt); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx[i] !== 8'(10 + i)) begin errors++; $display("FAIL stall_order[%0d]: got %h expected %h", i, rx[i], 8'(10 + i)); end
        end
        checks++; if (out_data !== 8'd11) begin errors++; $display("FAIL stall_read0: got %h expected 0b", out_data); end
    endtask

    task automatic test_length_errors();
        bit ok;
        mode = 0;
        for (int i = 0; i < 5; i++) write_word(8'(30 + i));
        commit();
        checks++; if (err !== 3'b010) begin errors++; $display("FAIL short_commit_err: got %b expected 010", err); end
        checks++; if (busy !== 1'b0 || m_in_valid !== 1'b0) begin errors++; $display("FAIL short_commit_state: busy=%b m_in_valid=%b expected 0 0", busy, m_in_valid); end
        for (int i = 5; i < 8; i++) write_word(8'(30 + i));
        commit();
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL short_done_timeout: ml_inf_valid=%b expected 1", ml_inf_valid); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_data !== 8'(31 + i)) begin errors++; $display("FAIL short_read[%0d]: got %h expected %h", i, out_data, 8'(31 + i)); end
            read_step();
        end
        for (int i = 0; i < 8; i++) write_word(8'(40 + i));
        write_word(8'd99);
        checks++; if (err !== 3'b011) begin errors++; $display("FAIL overflow_err: got %b expected 011", err); end
        commit();
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL overflow_done_timeout: ml_inf_valid=%b expected 1", ml_inf_valid); end
        checks++; if (out_data !== 8'd41) begin errors++; $display("FAIL overflow_read0: got %h expected 29", out_data); end
    endtask

    task automatic test_early_last();
        bit ok;
        mode = 2;
        in_cnt = 0;
        out_beats = 0;
        checks++; if (err[2] !== 1'b0) begin errors++; $display("FAIL early_err_before: got %b expected 0", err[2]); end
        commit();   // re-run of the buffered 40..47 vector
        checks++; if (ml_inf_valid !== 1'b0 || m_in_valid !== 1'b1) begin errors++; $display("FAIL rerun_start: valid=%b m_in_valid=%b expected 0 1", ml_inf_valid, m_in_valid); end
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL early_done_timeout: ml_inf_valid=%b expected 1", ml_inf_valid); end
        checks++; if (out_beats != 8) begin errors++; $display("FAIL early_beats_at_done: got %0d expected 8", out_beats); end
        checks++; if (err !== 3'b111) begin errors++; $display("FAIL early_err: got %b expected 111", err); end
        checks++; if (out_data !== 8'd41) begin errors++; $display("FAIL early_read0: got %h expected 29", out_data); end
        mode = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        mode = 0;
        for (int i = 0; i < 8; i++) write_word(8'(20 + i));
        commit();
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (m_out_ready === 1'b1) begin ok = 1; break; end
            tick();
        end
        checks++; if (!ok) begin errors++; $display("FAIL mid_collect_timeout: m_out_ready=%b expected 1", m_out_ready); end
        #1 sys_rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || m_out_ready !== 1'b0 || m_in_valid !== 1'b0 || m_in_last !== 1'b0) begin
            errors++; $display("FAIL mid_rst_stream: busy=%b m_out_ready=%b m_in_valid=%b m_in_last=%b expected 0 0 0 0", busy, m_out_ready, m_in_valid, m_in_last);
        end
        checks++; if (err !== 3'b000 || ml_inf_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL mid_rst_host: err=%b valid=%b out_data=%h expected 000 0 00", err, ml_inf_valid, out_data);
        end
        tick(); tick();
        sys_rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) write_word(8'(20 + i));
        commit();
        wait_done(200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL post_rst_timeout: ml_inf_valid=%b expected 1", ml_inf_valid); end
        checks++; if (err !== 3'b000) begin errors++; $display("FAIL post_rst_err: got %b expected 000", err); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_data !== 8'(21 + i)) begin errors++; $display("FAIL post_rst_read[%0d]: got %h expected %h", i, out_data, 8'(21 + i)); end
            read_step();
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_relu();
        test_stall();
        test_length_errors();
        test_early_last();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
